// File: rtl/imem_loader.sv
// Instruction memory loader: length-prefixed byte stream to IMEM words.
// Big-endian word assembly, per-byte gap timeout, sticky error flag.
module imem_loader #(
  parameter int IMEM_SIZE   = 64,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic        WE,
  output logic [31:0] W_Ins,
  output logic [31:0] W_Addr,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [15:0] WORDS
);

  localparam int GW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [GW-1:0] TO_LAST = GW'(TIMEOUT_CYC - 1);
  localparam logic [15:0]   MAX_LEN = 16'(IMEM_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_FINISH,
    S_ERROR
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0]    len_hi;
  logic [15:0]   len;
  logic [15:0]   word_idx;
  logic [1:0]    byte_idx;
  logic [23:0]   acc;
  logic [GW-1:0] gap;

  logic          loading;
  logic          start_ok;
  logic          timeout;
  logic          word_last;
  logic          prog_last;
  logic [15:0]   len_full;

  assign loading   = (state == S_LEN_HI) ||
                     (state == S_LEN_LO) ||
                     (state == S_DATA);
  assign start_ok  = START && ((state == S_IDLE) ||
                               (state == S_FINISH) ||
                               (state == S_ERROR));
  // A byte on the threshold cycle rescues the load.
  assign timeout   = loading && !RX_VALID && (gap == TO_LAST);
  assign word_last = (state == S_DATA) && RX_VALID &&
                     (byte_idx == 2'd3);
  assign prog_last = word_last && ((word_idx + 16'd1) == len);
  assign len_full  = {len_hi, RX_DATA};

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (START) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (RX_VALID)     state_nxt = S_LEN_LO;
        else if (timeout) state_nxt = S_ERROR;
      end
      S_LEN_LO: begin
        if (RX_VALID) begin
          if (len_full == 16'd0)         state_nxt = S_FINISH;
          else if (len_full > MAX_LEN)   state_nxt = S_ERROR;
          else                           state_nxt = S_DATA;
        end else if (timeout) begin
          state_nxt = S_ERROR;
        end
      end
      S_DATA: begin
        if (prog_last)    state_nxt = S_FINISH;
        else if (timeout) state_nxt = S_ERROR;
      end
      S_FINISH: begin
        state_nxt = START ? S_LEN_HI : S_IDLE;
      end
      S_ERROR: begin
        if (START) state_nxt = S_LEN_HI;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded status outputs.
  always_comb begin
    BUSY = loading;
    ERR  = (state == S_ERROR);
  end

  // Byte gap counter, restarted by every byte and by a new load.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                      gap <= '0;
    else if (start_ok || RX_VALID) gap <= '0;
    else if (loading)             gap <= gap + 1'b1;
  end

  // Length capture.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      len_hi <= '0;
      len    <= '0;
    end else if (RX_VALID) begin
      if (state == S_LEN_HI) len_hi <= RX_DATA;
      if (state == S_LEN_LO) len    <= len_full;
    end
  end

  // Word assembly and IMEM write port.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc      <= '0;
      byte_idx <= '0;
      word_idx <= '0;
      WORDS    <= '0;
      W_Ins    <= '0;
      W_Addr   <= '0;
      WE       <= 1'b0;
    end else begin
      WE <= word_last;
      if (start_ok) begin
        byte_idx <= '0;
        word_idx <= '0;
        WORDS    <= '0;
      end else if ((state == S_DATA) && RX_VALID) begin
        if (byte_idx == 2'd3) begin
          W_Ins    <= {acc, RX_DATA};
          W_Addr   <= {14'd0, word_idx, 2'b00};
          word_idx <= word_idx + 16'd1;
          WORDS    <= WORDS + 16'd1;
          byte_idx <= 2'd0;
        end else begin
          acc      <= {acc[15:0], RX_DATA};
          byte_idx <= byte_idx + 2'd1;
        end
      end
    end
  end

  // Completion pulse, one cycle after entering FINISH.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) DONE <= 1'b0;
    else     DONE <= (state == S_FINISH);
  end

endmodule
